// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-road intersection controller.
// The main road rests on green. The side road is served on a latched demand.
// Optional build macro TLC_FLASH_MODE_EN adds the flash_en input and a FLASH state.
// In FLASH, main blinks yellow and side blinks red.
module traffic_light_ctrl #(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned GREEN_T      = 8,
    parameter int unsigned YELLOW_T     = 3,
    parameter int unsigned ALLRED_T     = 2,
    parameter int unsigned SIDE_GREEN_T = 5,
    parameter int unsigned FLASH_T      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       side_req,
`ifdef TLC_FLASH_MODE_EN
    input  logic       flash_en,
`endif
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       side_ack,
    output logic [2:0] phase
);

    localparam logic [2:0] LAMP_RED = 3'b001;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b100;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
`ifdef TLC_FLASH_MODE_EN
        ALL_RED_B   = 3'd5,
        FLASH       = 3'd6
`else
        ALL_RED_B   = 3'd5
`endif
    } state_t;

    // Reject zero-length phases at elaboration time
    if (GREEN_T < 1 || YELLOW_T < 1 || ALLRED_T < 1 || SIDE_GREEN_T < 1 || FLASH_T < 1) begin : g_param_check
        $error("traffic_light_ctrl: every phase duration must be at least 1");
    end

    state_t           state, next_state;
    logic [CNT_W-1:0] timer, next_timer;
    logic             pending, next_pending;
    logic [2:0]       main_c, side_c;
`ifdef TLC_FLASH_MODE_EN
    logic             blink, next_blink;
`endif

    // Next-state, phase timer and side-demand latch
    always_comb begin
        next_state   = state;
        next_timer   = (timer != '0) ? timer - CNT_W'(1) : timer;
        next_pending = pending;
`ifdef TLC_FLASH_MODE_EN
        next_blink   = blink;
`endif
        case (state)
            MAIN_GREEN: begin
                // Rest on green with the timer parked at zero until demand shows up
                if (timer == '0 && (pending || side_req)) begin
                    next_state = MAIN_YELLOW;
                    next_timer = CNT_W'(YELLOW_T - 1);
                end
            end
            MAIN_YELLOW: begin
                if (timer == '0) begin
                    next_state = ALL_RED_A;
                    next_timer = CNT_W'(ALLRED_T - 1);
                end
            end
            ALL_RED_A: begin
                if (timer == '0) begin
                    next_state = SIDE_GREEN;
                    next_timer = CNT_W'(SIDE_GREEN_T - 1);
                end
            end
            SIDE_GREEN: begin
                if (timer == '0) begin
                    next_state = SIDE_YELLOW;
                    next_timer = CNT_W'(YELLOW_T - 1);
                end
            end
            SIDE_YELLOW: begin
                if (timer == '0) begin
                    next_state = ALL_RED_B;
                    next_timer = CNT_W'(ALLRED_T - 1);
                end
            end
            ALL_RED_B: begin
                if (timer == '0) begin
                    next_state = MAIN_GREEN;
                    next_timer = CNT_W'(GREEN_T - 1);
                end
            end
`ifdef TLC_FLASH_MODE_EN
            FLASH: begin
                // The timer counts the half-period; toggle the lamp at each expiry
                if (timer == '0) begin
                    next_timer = CNT_W'(FLASH_T - 1);
                    next_blink = ~blink;
                end
            end
`endif
            default: begin
                next_state = ALL_RED_B;
                next_timer = CNT_W'(ALLRED_T - 1);
            end
        endcase

`ifdef TLC_FLASH_MODE_EN
        // Flash request overrides timers and demand; leaving flash re-clears via all-red
        if (flash_en) begin
            if (state != FLASH) begin
                next_state = FLASH;
                next_timer = CNT_W'(FLASH_T - 1);
                next_blink = 1'b0;
            end
        end else if (state == FLASH) begin
            next_state = ALL_RED_B;
            next_timer = CNT_W'(ALLRED_T - 1);
            next_blink = 1'b0;
        end
`endif

        // Demand is latched everywhere except while the side road is already green
        if (side_req && state != SIDE_GREEN) begin
            next_pending = 1'b1;
        end
        // Serving the side road consumes the demand, even against a same-cycle request
        if (next_state == SIDE_GREEN && state != SIDE_GREEN) begin
            next_pending = 1'b0;
        end
    end

    // Lamp decode of the upcoming state so the registered lamps track the state register
    always_comb begin
        main_c = LAMP_RED;
        side_c = LAMP_RED;
        case (next_state)
            MAIN_GREEN:  main_c = LAMP_GRN;
            MAIN_YELLOW: main_c = LAMP_YEL;
            SIDE_GREEN:  side_c = LAMP_GRN;
            SIDE_YELLOW: side_c = LAMP_YEL;
`ifdef TLC_FLASH_MODE_EN
            FLASH: begin
                main_c = next_blink ? LAMP_OFF : LAMP_YEL;
                side_c = next_blink ? LAMP_OFF : LAMP_RED;
            end
`endif
            default: begin
                main_c = LAMP_RED;
                side_c = LAMP_RED;
            end
        endcase
    end

    // State register with registered lamp, phase and acknowledge outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ALL_RED_B;
            timer      <= CNT_W'(ALLRED_T - 1);
            pending    <= 1'b0;
            main_light <= LAMP_RED;
            side_light <= LAMP_RED;
            side_ack   <= 1'b0;
            phase      <= 3'd5;
`ifdef TLC_FLASH_MODE_EN
            blink      <= 1'b0;
`endif
        end else begin
            state      <= next_state;
            timer      <= next_timer;
            pending    <= next_pending;
            main_light <= main_c;
            side_light <= side_c;
            side_ack   <= (next_state == SIDE_GREEN) && (state != SIDE_GREEN);
            phase      <= next_state;
`ifdef TLC_FLASH_MODE_EN
            blink      <= next_blink;
`endif
        end
    end

endmodule
